// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED among NREQ status sources, with a minimum dwell per grant.
// Optional per-requester blinking is built when RGB_ARB_BLINK_EN is defined.
module rgb_led_arbiter #(
    parameter int NREQ       = 4,
    parameter int DWELL      = 24_000_000,
    parameter int BLINK_HALF = 12_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [3*NREQ-1:0]   i_colour,
    input  logic [NREQ-1:0]     i_blink,
    output logic [NREQ-1:0]     o_gnt,
    output logic                o_ledr,
    output logic                o_ledg,
    output logic                o_ledb
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r, state_n;
    logic [IW-1:0]   idx_r, idx_n;
    logic [IW-1:0]   ptr_r, ptr_n;
    logic [DW-1:0]   dwell_r, dwell_n;
    logic [NREQ-1:0] gnt_r, gnt_n, others_s;
    logic [2:0]      led_r, led_n, col_s;
    logic [IW+1:0]   sh_s;
    logic [IW:0]     hit_s;
    logic            new_gnt_s, dwell_done_s, blank_s;

    // First set bit of req at or above start, with wrap-around; MSB flags a hit.
    function automatic logic [IW:0] pick(input logic [NREQ-1:0] req, input logic [IW-1:0] start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(start) + i) % NREQ);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] succ(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? IW'(0) : idx + IW'(1);
    endfunction

    assign dwell_done_s = (dwell_r >= DW'(DWELL - 1));
    assign others_s     = i_req & ~({{(NREQ-1){1'b0}}, 1'b1} << idx_r);

    // Arbitration: next state, next holder and whether a fresh grant starts.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        new_gnt_s = 1'b0;
        hit_s     = '0;
        case (state_r)
            IDLE: begin
                hit_s = pick(i_req, ptr_r);
                if (hit_s[IW]) begin
                    state_n   = GRANT;
                    idx_n     = hit_s[IW-1:0];
                    new_gnt_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (!i_req[idx_r]) begin
                    hit_s = pick(i_req, succ(idx_r));
                    if (hit_s[IW]) begin
                        idx_n     = hit_s[IW-1:0];
                        new_gnt_s = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (dwell_done_s) begin
                    // Holder is excluded so it only keeps the LED when nobody else wants it.
                    hit_s = pick(others_s, succ(idx_r));
                    if (hit_s[IW]) begin
                        idx_n     = hit_s[IW-1:0];
                        new_gnt_s = 1'b1;
                    end else begin
                        state_n = GRANT;
                    end
                end else begin
                    state_n = GRANT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pointer and saturating dwell counter for the upcoming cycle.
    always_comb begin
        if (new_gnt_s) begin
            ptr_n = succ(idx_n);
        end else begin
            ptr_n = ptr_r;
        end
        if (new_gnt_s || (state_n != GRANT)) begin
            dwell_n = '0;
        end else if (dwell_r == DW'(DWELL)) begin
            dwell_n = dwell_r;
        end else begin
            dwell_n = dwell_r + DW'(1);
        end
    end

`ifdef RGB_ARB_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] blink_cnt_r, blink_cnt_n;
    logic          phase_r, phase_n;

    // Blink phase restarts "on" with each grant and flips every BLINK_HALF cycles.
    always_comb begin
        if (new_gnt_s || (state_n != GRANT)) begin
            blink_cnt_n = '0;
            phase_n     = 1'b1;
        end else if (blink_cnt_r == BW'(BLINK_HALF - 1)) begin
            blink_cnt_n = '0;
            phase_n     = ~phase_r;
        end else begin
            blink_cnt_n = blink_cnt_r + BW'(1);
            phase_n     = phase_r;
        end
        blank_s = i_blink[idx_n] & ~phase_n;
    end

    // Blink counter and phase registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else begin
            blink_cnt_r <= blink_cnt_n;
            phase_r     <= phase_n;
        end
    end
`else
    logic unused_blink_s;
    assign unused_blink_s = (^i_blink) ^ (BLINK_HALF > 0);
    assign blank_s        = 1'b0;
`endif

    // Next registered outputs: grant one-hot and the holder's colour, gated by blink.
    always_comb begin
        sh_s  = {2'b00, idx_n} + {1'b0, idx_n, 1'b0};
        col_s = 3'(i_colour >> sh_s);
        if (state_n == GRANT) begin
            gnt_n = {{(NREQ-1){1'b0}}, 1'b1} << idx_n;
            led_n = col_s & ~{3{blank_s}};
        end else begin
            gnt_n = '0;
            led_n = 3'b000;
        end
    end

    // State, pointer, dwell and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            ptr_r   <= '0;
            dwell_r <= '0;
            gnt_r   <= '0;
            led_r   <= 3'b000;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            ptr_r   <= ptr_n;
            dwell_r <= dwell_n;
            gnt_r   <= gnt_n;
            led_r   <= led_n;
        end
    end

    assign o_gnt  = gnt_r;
    assign o_ledr = led_r[2];
    assign o_ledg = led_r[1];
    assign o_ledb = led_r[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench for rgb_led_arbiter: a grant-level reference model queues the expected
// outputs per edge and a monitor compares them against the DUT.
module tb_rgb_led_arbiter;

    localparam int NREQ       = 4;
    localparam int DWELL      = 4;
    localparam int BLINK_HALF = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] colour = 12'h000;
    logic [3:0]  blink = 4'b0000;
    logic [3:0]  gnt;
    logic        ledr, ledg, ledb;

    int n_cmp = 0;
    int n_bad = 0;

    int m_holder = -1;
    int m_held   = 0;
    int m_ptr    = 0;

    logic [6:0] exp_q[$];
    logic [6:0] mon_e;
    logic [3:0] rr;

    always #5 clk = ~clk;

    rgb_led_arbiter #(
        .NREQ(NREQ),
        .DWELL(DWELL),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req(req),
        .i_colour(colour),
        .i_blink(blink),
        .o_gnt(gnt),
        .o_ledr(ledr),
        .o_ledg(ledg),
        .o_ledb(ledb)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int start);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(start + i) % NREQ]) return (start + i) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: advance one clock edge with the given inputs, queue expected outputs.
    task automatic apply(input logic [3:0] r, input logic [11:0] c, input logic [3:0] b);
        int f;
        logic [3:0] eg;
        logic [2:0] el;
        req = r; colour = c; blink = b;
        if (m_holder < 0) begin
            f = search(r, m_ptr);
            if (f >= 0) begin m_holder = f; m_held = 1; m_ptr = (f + 1) % NREQ; end
        end else if (!r[m_holder]) begin
            f = search(r, (m_holder + 1) % NREQ);
            m_ptr = (m_holder + 1) % NREQ;
            if (f >= 0) begin m_holder = f; m_held = 1; m_ptr = (f + 1) % NREQ; end
            else m_holder = -1;
        end else begin
            f = search(r & ~(4'b0001 << m_holder), (m_holder + 1) % NREQ);
            if (m_held >= DWELL && f >= 0) begin
                m_holder = f; m_held = 1; m_ptr = (f + 1) % NREQ;
            end else begin
                m_held++;
            end
        end
        if (m_holder < 0) begin
            eg = 4'b0000; el = 3'b000;
        end else begin
            eg = 4'(4'b0001 << m_holder);
            el = 3'(c >> (3 * m_holder));
`ifdef RGB_ARB_BLINK_EN
            if (b[m_holder] && (((m_held - 1) / BLINK_HALF) % 2 == 1)) el = 3'b000;
`endif
        end
        exp_q.push_back({eg, el});
    endtask

    task automatic step(input logic [3:0] r, input logic [11:0] c, input logic [3:0] b);
        @(negedge clk);
        apply(r, c, b);
    endtask

    // Asynchronous reset between edges, outputs checked before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_holder = -1; m_held = 0; m_ptr = 0;
        #1;
        check("rst_async_gnt", {28'd0, gnt}, 32'd0);
        check("rst_async_led", {29'd0, ledr, ledg, ledb}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            req = 4'($urandom); colour = 12'($urandom); blink = 4'($urandom);
            exp_q.push_back(7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0000, 12'h000, 4'b0000);
    endtask

    // Monitor: compare every edge's outputs against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gnt", {28'd0, gnt}, {28'd0, mon_e[6:3]});
            check("led", {29'd0, ledr, ledg, ledb}, {29'd0, mon_e[2:0]});
        end
    end

    initial begin
        do_reset();
        repeat (3) step(4'b0000, 12'h000, 4'b0000);

        // single requester, long hold, colour change mid-grant
        repeat (22) step(4'b0001, 12'o0005, 4'b0000);
        repeat (3)  step(4'b0001, 12'o0002, 4'b0000);

        // reset while slot0 holds the LED, then idle
        do_reset();
        repeat (3) step(4'b0000, 12'o7531, 4'b0000);

        // contention: slot2 arrives during slot0's first grant cycle
        step(4'b0001, 12'o7531, 4'b0000);
        repeat (10) step(4'b0101, 12'o7531, 4'b0000);
        repeat (2) step(4'b0000, 12'o7531, 4'b0000);

        // round-robin from reset
        do_reset();
        repeat (22) step(4'b1111, 12'o7531, 4'b0000);

        // early release then pointer continues after slot1
        do_reset();
        repeat (2) step(4'b0010, 12'o7531, 4'b0000);
        step(4'b0000, 12'o7531, 4'b0000);
        repeat (6) step(4'b1010, 12'o7531, 4'b0000);

        // blink request on slot0
        do_reset();
        repeat (14) step(4'b0001, 12'o0007, 4'b0001);

        // randomized traffic with a mid-run reset
        rr = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 5) == 0) rr[k] = ~rr[k];
            end
            if (n == 200) do_reset();
            step(rr, 12'($urandom), 4'($urandom));
        end
        repeat (2) step(4'b0000, 12'h000, 4'b0000);

        @(posedge clk);
        #3;
        check("queue_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
